// File: rtl/target_pkg.sv
// rtl/target_pkg.sv - shared types and constants for the target generator
package target_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PICK = 2'd1,
      ST_SHOW = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   localparam logic [15:0] LFSR_TAPS  = 16'hB400;
   localparam int          MAX_REJECT = 8;
   localparam logic [13:0] MISS_MAX   = 14'h3FFF;

   // Whole-ms conversion; never returns less than one cycle.
   function automatic int ms_to_cycles(input int clk_hz, input int ms);
      int cyc;
      cyc = (clk_hz / 1000) * ms;
      return (cyc < 1) ? 1 : cyc;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Galois LFSR, steps every clock
module lfsr16
   import target_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] o_state
);

   // An all-zero state would lock up the register.
   localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

   logic [15:0] r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SEED_NZ;
      end else begin
         r_state <= {1'b0, r_state[15:1]} ^ (r_state[0] ? LFSR_TAPS : 16'h0000);
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/target_generator.sv
// rtl/target_generator.sv - picks, shows and retires one-hot switch targets
// Optional TARGET_SPEEDUP_EN: target lifetime shrinks after every hit.
module target_generator
   import target_pkg::*;
#(
   parameter int          N_SW      = 18,
   parameter int          CLK_HZ    = 50_000_000,
   parameter int          TARGET_MS = 1000,
   parameter int          GAP_MS    = 200,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      game_over,
   input  logic                      target_hit,
   output logic [N_SW-1:0]           curr_target,
   output logic [$clog2(N_SW)-1:0]   target_idx,
   output logic                      target_valid,
   output logic                      miss_pulse,
   output logic [13:0]               miss_count
);

   localparam int IDX_W      = $clog2(N_SW);
   localparam int TARGET_CYC = ms_to_cycles(CLK_HZ, TARGET_MS);
   localparam int GAP_CYC    = ms_to_cycles(CLK_HZ, GAP_MS);
   localparam int MAX_CYC    = (TARGET_CYC > GAP_CYC) ? TARGET_CYC : GAP_CYC;
   localparam int TMR_W      = $clog2(MAX_CYC) + 1;
   localparam int REJ_W      = $clog2(MAX_REJECT);

   localparam logic [REJ_W-1:0] REJ_LAST = REJ_W'(MAX_REJECT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SW - 1);
   localparam logic [N_SW-1:0]  ONE_HOT0 = {{(N_SW-1){1'b0}}, 1'b1};

   state_t            r_state;
   state_t            w_next_state;
   logic [15:0]       w_lfsr;
   logic              w_unused;
   logic [TMR_W-1:0]  r_timer;
   logic [TMR_W-1:0]  w_life;
   logic [REJ_W-1:0]  r_rej;
   logic              r_first;
   logic [IDX_W-1:0]  w_cand;
   logic [IDX_W-1:0]  w_fallback;
   logic [IDX_W-1:0]  w_pick_idx;
   logic              w_cand_ok;
   logic              w_force;
   logic              w_accept;
   logic              w_reject;
   logic              w_timeout;
   logic              w_gap_done;
   logic              w_start_go;
   logic              w_load;
   logic              w_hit;
   logic              w_miss;
   logic              w_clear;
   logic              w_timer_run;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .o_state (w_lfsr)
   );

   assign w_cand     = w_lfsr[IDX_W-1:0];
   assign w_unused   = ^w_lfsr[15:IDX_W];
   assign w_cand_ok  = (32'(w_cand) < N_SW) && (r_first || (w_cand != target_idx));
   assign w_fallback = (target_idx >= IDX_LAST) ? '0 : target_idx + IDX_W'(1);
   assign w_force    = !w_cand_ok && (r_rej == REJ_LAST);
   assign w_pick_idx = w_cand_ok ? w_cand : w_fallback;
   assign w_accept   = (r_state == ST_PICK) && (w_cand_ok || w_force);
   assign w_reject   = (r_state == ST_PICK) && !w_cand_ok && !w_force;
   assign w_timeout  = (r_state == ST_SHOW) && (r_timer == w_life - TMR_W'(1));
   assign w_gap_done = (r_state == ST_GAP) && (r_timer == TMR_W'(GAP_CYC - 1));

`ifdef TARGET_SPEEDUP_EN
   localparam int LIFE_MIN = ((TARGET_CYC >> 2) < 1) ? 1 : (TARGET_CYC >> 2);

   logic [TMR_W-1:0] r_life;
   logic [TMR_W-1:0] w_life_dec;

   assign w_life_dec = r_life - (r_life >> 4);
   assign w_life     = r_life;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_life <= TMR_W'(TARGET_CYC);
      end else if (w_start_go) begin
         r_life <= TMR_W'(TARGET_CYC);
      end else if (w_hit) begin
         r_life <= (w_life_dec < TMR_W'(LIFE_MIN)) ? TMR_W'(LIFE_MIN) : w_life_dec;
      end
   end
`else
   assign w_life = TMR_W'(TARGET_CYC);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (game_over) begin
         w_next_state = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (start)                    w_next_state = ST_PICK;
            ST_PICK: if (w_accept)                 w_next_state = ST_SHOW;
            ST_SHOW: if (target_hit || w_timeout)  w_next_state = ST_GAP;
            ST_GAP:  if (w_gap_done)               w_next_state = ST_PICK;
            default:                               w_next_state = ST_IDLE;
         endcase
      end
   end

   // A hit landing on the final visible cycle wins over the timeout.
   always_comb begin
      w_start_go  = 1'b0;
      w_load      = 1'b0;
      w_hit       = 1'b0;
      w_miss      = 1'b0;
      w_clear     = 1'b0;
      w_timer_run = 1'b0;
      if (game_over) begin
         w_clear = 1'b1;
      end else begin
         w_start_go  = (r_state == ST_IDLE) && start;
         w_load      = w_accept;
         w_hit       = (r_state == ST_SHOW) && target_hit;
         w_miss      = w_timeout && !target_hit;
         w_clear     = w_hit || w_miss;
         w_timer_run = ((r_state == ST_SHOW) || (r_state == ST_GAP)) && (w_next_state == r_state);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer      <= '0;
         r_rej        <= '0;
         r_first      <= 1'b0;
         curr_target  <= '0;
         target_idx   <= '0;
         target_valid <= 1'b0;
         miss_pulse   <= 1'b0;
         miss_count   <= '0;
      end else begin
         r_timer    <= w_timer_run ? r_timer + TMR_W'(1) : '0;
         r_rej      <= w_reject ? r_rej + REJ_W'(1) : '0;
         miss_pulse <= w_miss;

         if (w_start_go) begin
            r_first <= 1'b1;
         end else if (w_load) begin
            r_first <= 1'b0;
         end

         if (w_start_go) begin
            miss_count <= '0;
         end else if (w_miss && (miss_count != MISS_MAX)) begin
            miss_count <= miss_count + 14'd1;
         end

         if (w_load) begin
            curr_target  <= ONE_HOT0 << w_pick_idx;
            target_idx   <= w_pick_idx;
            target_valid <= 1'b1;
         end else if (w_clear) begin
            curr_target  <= '0;
            target_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_target_generator.sv
// tb/tb_target_generator.sv - randomized self-checking bench for target_generator
module tb_target_generator;

   localparam int N1   = 18;
   localparam int N2   = 2;
   localparam int TCYC = 10;
   localparam int GCYC = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start, game_over, target_hit;
   logic [17:0] curr_target;
   logic [4:0]  target_idx;
   logic        target_valid, miss_pulse;
   logic [13:0] miss_count;
   logic        start2, game_over2, target_hit2;
   logic [1:0]  curr_target2;
   logic [0:0]  target_idx2;
   logic        target_valid2, miss_pulse2;
   logic [13:0] miss_count2;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] m_lfsr = 16'hACE1;
   int          prev_idx = 0;
   int          exp_miss = 0;
   int          exp_idx, exp_n;
   logic [17:0] one18 = 18'd1;

   always #5 clk = ~clk;

   target_generator #(.N_SW(N1), .CLK_HZ(1000), .TARGET_MS(10), .GAP_MS(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .game_over(game_over), .target_hit(target_hit),
      .curr_target(curr_target), .target_idx(target_idx), .target_valid(target_valid),
      .miss_pulse(miss_pulse), .miss_count(miss_count)
   );

   target_generator #(.N_SW(N2), .CLK_HZ(1000), .TARGET_MS(10), .GAP_MS(3)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .game_over(game_over2), .target_hit(target_hit2),
      .curr_target(curr_target2), .target_idx(target_idx2), .target_valid(target_valid2),
      .miss_pulse(miss_pulse2), .miss_count(miss_count2)
   );

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int k);
      logic [15:0] x = v;
      for (int i = 0; i < k; i++) x = lfsr_next(x);
      return x;
   endfunction

   // Pick rule: walk the LFSR sequence from the first PICK cycle.
   task automatic pick_model(input logic [15:0] v0, input int prev, input bit first,
                             input int nsw, input int idxw, output int idx, output int n);
      logic [15:0] v = v0;
      int cand;
      for (int j = 0; j < 8; j++) begin
         cand = int'(v) % (1 << idxw);
         if (cand < nsw && (first || cand != prev)) begin
            idx = cand;
            n   = j + 1;
            return;
         end
         v = lfsr_next(v);
      end
      idx = (prev + 1) % nsw;
      n   = 8;
   endtask

   task automatic tick;
      @(posedge clk);
      if (rst_n) m_lfsr = lfsr_next(m_lfsr);
      #1;
   endtask

   task automatic await1(output int cyc);
      cyc = 0;
      do begin tick; cyc++; end while (!target_valid && cyc < 40);
   endtask

   task automatic await2(output int cyc);
      cyc = 0;
      do begin tick; cyc++; end while (!target_valid2 && cyc < 40);
   endtask

   task automatic test_reset;
      start = 0; game_over = 0; target_hit = 0;
      start2 = 0; game_over2 = 0; target_hit2 = 0;
      rst_n = 0;
      repeat (3) tick;
      rst_n = 1;
      for (int i = 0; i < 50; i++) begin
         tick;
         checks++;
         if ({curr_target, target_idx, target_valid, miss_pulse, miss_count} !== '0) begin
            errors++;
            $display("FAIL reset_idle cyc %0d: tgt=%h idx=%0d v=%b mp=%b mc=%0d, expected all 0",
                     i, curr_target, target_idx, target_valid, miss_pulse, miss_count);
         end
      end
      checks++;
      if ({curr_target2, target_idx2, target_valid2, miss_pulse2, miss_count2} !== '0) begin
         errors++;
         $display("FAIL reset_dut2: tgt=%b v=%b mc=%0d, expected 0", curr_target2, target_valid2, miss_count2);
      end
   endtask

   task automatic test_start;
      int cyc;
      start = 1; tick; start = 0;
      pick_model(m_lfsr, prev_idx, 1'b1, N1, 5, exp_idx, exp_n);
      await1(cyc);
      checks++;
      if (cyc != exp_n) begin
         errors++; $display("FAIL start_latency: got %0d cycles, expected %0d", cyc, exp_n);
      end
      checks++;
      if (target_idx !== 5'(exp_idx) || curr_target !== (one18 << exp_idx) || target_valid !== 1'b1) begin
         errors++; $display("FAIL start_target: idx=%0d tgt=%h v=%b, expected idx %0d", target_idx, curr_target, target_valid, exp_idx);
      end
      prev_idx = exp_idx;
      exp_miss = 0;
   endtask

   task automatic test_hit;
      int cyc, old;
      repeat (3) tick;
      checks++;
      if (curr_target !== (one18 << prev_idx)) begin
         errors++; $display("FAIL hit_hold: tgt=%h, expected %h", curr_target, one18 << prev_idx);
      end
      target_hit = 1; tick; target_hit = 0;
      checks++;
      if (curr_target !== '0 || target_valid !== 1'b0 || miss_pulse !== 1'b0 || miss_count !== 14'(exp_miss)) begin
         errors++; $display("FAIL hit_clear: tgt=%h v=%b mp=%b mc=%0d, expected 0/0/0/%0d", curr_target, target_valid, miss_pulse, miss_count, exp_miss);
      end
      pick_model(lfsr_adv(m_lfsr, GCYC), prev_idx, 1'b0, N1, 5, exp_idx, exp_n);
      old = prev_idx;
      await1(cyc);
      checks++;
      if (cyc != GCYC + exp_n) begin
         errors++; $display("FAIL hit_gap: got %0d blank cycles, expected %0d", cyc, GCYC + exp_n);
      end
      checks++;
      if (target_idx !== 5'(exp_idx) || int'(target_idx) == old || curr_target !== (one18 << exp_idx)) begin
         errors++; $display("FAIL hit_next: idx=%0d tgt=%h, expected idx %0d (prev %0d)", target_idx, curr_target, exp_idx, old);
      end
      prev_idx = exp_idx;
   endtask

   task automatic test_timeout;
      int vis, cyc;
      vis = 1;
      for (int k = 0; k < 40; k++) begin tick; if (!target_valid) break; vis++; end
      checks++;
      if (vis != TCYC) begin
         errors++; $display("FAIL timeout_len: visible %0d cycles, expected %0d", vis, TCYC);
      end
      exp_miss++;
      checks++;
      if (miss_pulse !== 1'b1 || miss_count !== 14'(exp_miss)) begin
         errors++; $display("FAIL timeout_miss: mp=%b mc=%0d, expected 1/%0d", miss_pulse, miss_count, exp_miss);
      end
      pick_model(lfsr_adv(m_lfsr, GCYC), prev_idx, 1'b0, N1, 5, exp_idx, exp_n);
      tick;
      checks++;
      if (miss_pulse !== 1'b0) begin
         errors++; $display("FAIL timeout_pulse_width: mp=%b, expected 0", miss_pulse);
      end
      await1(cyc);
      checks++;
      if (cyc + 1 != GCYC + exp_n || target_idx !== 5'(exp_idx)) begin
         errors++; $display("FAIL timeout_next: blank %0d idx %0d, expected %0d idx %0d", cyc + 1, target_idx, GCYC + exp_n, exp_idx);
      end
      prev_idx = exp_idx;
   endtask

   task automatic test_hit_at_timeout;
      int cyc;
      repeat (9) tick;
      target_hit = 1; tick; target_hit = 0;
      checks++;
      if (curr_target !== '0 || miss_pulse !== 1'b0 || miss_count !== 14'(exp_miss)) begin
         errors++; $display("FAIL hit_final_cycle: tgt=%h mp=%b mc=%0d, expected 0/0/%0d", curr_target, miss_pulse, miss_count, exp_miss);
      end
      pick_model(lfsr_adv(m_lfsr, GCYC), prev_idx, 1'b0, N1, 5, exp_idx, exp_n);
      await1(cyc);
      checks++;
      if (cyc != GCYC + exp_n || target_idx !== 5'(exp_idx) || miss_count !== 14'(exp_miss)) begin
         errors++; $display("FAIL hit_final_next: blank %0d idx %0d mc %0d, expected %0d idx %0d mc %0d",
                            cyc, target_idx, miss_count, GCYC + exp_n, exp_idx, exp_miss);
      end
      prev_idx = exp_idx;
   endtask

   task automatic test_game_over;
      int cyc;
      bit stray;
      repeat (2) tick;
      game_over = 1; start = 1; tick; start = 0;
      checks++;
      if (curr_target !== '0 || target_valid !== 1'b0 || miss_pulse !== 1'b0 ||
          miss_count !== 14'(exp_miss) || target_idx !== 5'(prev_idx)) begin
         errors++; $display("FAIL game_over_clear: tgt=%h v=%b mp=%b mc=%0d idx=%0d, expected 0/0/0/%0d/%0d",
                            curr_target, target_valid, miss_pulse, miss_count, target_idx, exp_miss, prev_idx);
      end
      repeat (5) tick;
      game_over = 0;
      stray = 0;
      for (int i = 0; i < 20; i++) begin tick; if (target_valid !== 1'b0 || curr_target !== '0) stray = 1; end
      checks++;
      if (stray || miss_count !== 14'(exp_miss)) begin
         errors++; $display("FAIL game_over_idle: stray=%b mc=%0d, expected 0/%0d", stray, miss_count, exp_miss);
      end
      start = 1; tick; start = 0;
      exp_miss = 0;
      checks++;
      if (miss_count !== 14'd0) begin
         errors++; $display("FAIL restart_clear: mc=%0d, expected 0", miss_count);
      end
      pick_model(m_lfsr, prev_idx, 1'b1, N1, 5, exp_idx, exp_n);
      await1(cyc);
      checks++;
      if (cyc != exp_n || target_idx !== 5'(exp_idx)) begin
         errors++; $display("FAIL restart_target: lat %0d idx %0d, expected %0d idx %0d", cyc, target_idx, exp_n, exp_idx);
      end
      prev_idx = exp_idx;
   endtask

   task automatic test_many_timeouts;
      bit seen[18];
      int vis, cyc, nseen, prev_obs;
      prev_obs = int'(target_idx);
      for (int it = 0; it < 2000; it++) begin
         vis = 1;
         for (int k = 0; k < 40; k++) begin tick; if (!target_valid) break; vis++; end
         checks++;
         if (vis != TCYC || miss_pulse !== 1'b1) begin
            errors++; $display("FAIL many_expire it %0d: visible %0d mp=%b, expected %0d and 1", it, vis, miss_pulse, TCYC);
         end
         exp_miss++;
         pick_model(lfsr_adv(m_lfsr, GCYC), prev_idx, 1'b0, N1, 5, exp_idx, exp_n);
         await1(cyc);
         checks++;
         if (cyc != GCYC + exp_n || target_idx !== 5'(exp_idx) || curr_target !== (one18 << exp_idx)) begin
            errors++; $display("FAIL many_pick it %0d: blank %0d idx %0d, expected %0d idx %0d", it, cyc, target_idx, GCYC + exp_n, exp_idx);
         end
         checks++;
         if (int'(target_idx) == prev_obs || target_idx >= 5'd18) begin
            errors++; $display("FAIL many_rule it %0d: idx %0d after %0d, expected new index below 18", it, target_idx, prev_obs);
         end
         if (target_idx < 5'd18) seen[target_idx] = 1'b1;
         prev_obs = int'(target_idx);
         prev_idx = exp_idx;
      end
      checks++;
      if (miss_count !== 14'd2000) begin
         errors++; $display("FAIL many_count: mc=%0d, expected 2000", miss_count);
      end
      nseen = 0;
      foreach (seen[i]) nseen += int'(seen[i]);
      checks++;
      if (nseen != 18) begin
         errors++; $display("FAIL many_coverage: %0d distinct indices, expected 18", nseen);
      end
   endtask

   task automatic test_two_switches;
      int cyc, prev2;
      game_over = 1;
      tick;
      start2 = 1; tick; start2 = 0;
      pick_model(m_lfsr, 0, 1'b1, N2, 1, exp_idx, exp_n);
      await2(cyc);
      checks++;
      if (cyc != exp_n || target_idx2 !== 1'(exp_idx) || curr_target2 !== (2'd1 << exp_idx)) begin
         errors++; $display("FAIL n2_first: lat %0d idx %0d, expected %0d idx %0d", cyc, target_idx2, exp_n, exp_idx);
      end
      prev2 = exp_idx;
      for (int it = 0; it < 500; it++) begin
         target_hit2 = 1; tick; target_hit2 = 0;
         pick_model(lfsr_adv(m_lfsr, GCYC), prev2, 1'b0, N2, 1, exp_idx, exp_n);
         await2(cyc);
         checks++;
         if (cyc != GCYC + exp_n || target_idx2 !== 1'(exp_idx) || int'(target_idx2) != 1 - prev2 ||
             curr_target2 !== (2'd1 << exp_idx)) begin
            errors++; $display("FAIL n2_alternate it %0d: blank %0d idx %0d, expected %0d idx %0d", it, cyc, target_idx2, GCYC + exp_n, exp_idx);
         end
         prev2 = exp_idx;
      end
      checks++;
      if (target_valid !== 1'b0 || curr_target !== '0) begin
         errors++; $display("FAIL n2_main_idle: v=%b tgt=%h, expected 0", target_valid, curr_target);
      end
   endtask

   initial begin
      test_reset;
      test_start;
      test_hit;
      test_timeout;
      test_hit_at_timeout;
      test_game_over;
      test_many_timeouts;
      test_two_switches;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
